// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS sequencer.
// Opcode dispatch lives here so decode rules stay in one place.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_EXEC_I,
      S_WB_I,
      S_BRANCH,
      S_JUMP,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b000110;
   localparam logic [5:0] OP_SUBI  = 6'b000111;
   localparam logic [5:0] OP_ANDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001001;
   localparam logic [5:0] OP_BEQ   = 6'b000011;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] ALU_ADD   = 6'b000110;
   localparam logic [5:0] ALU_SUB   = 6'b000111;
   localparam logic [5:0] ALU_RTYPE = 6'b111111;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

   // Unknown opcodes map to S_HALT; the caller flags the illegal-opcode error.
   function automatic state_t dispatch(input logic [5:0] op);
      state_t s;
      case (op)
         OP_RTYPE:                          s = S_EXEC_R;
         OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: s = S_EXEC_I;
         OP_BEQ:                            s = S_BRANCH;
         OP_LW, OP_SW:                      s = S_MEM_ADDR;
         OP_J:                              s = S_JUMP;
         default:                           s = S_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles while a memory access is pending.
// MAX_WAIT = 0 disables expiry entirely.
module mc_wait_timer #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic ready,
   output logic expired
);

   localparam int unsigned   CW    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

   logic [CW-1:0] count;

   // Saturates at LIMIT; ready or leaving a wait state restarts the count.
   always_ff @(posedge clk) begin
      if (reset || !active || ready) begin
         count <= '0;
      end else if (count != LIMIT) begin
         count <= count + CW'(1);
      end
   end

   always_comb begin
      expired = (MAX_WAIT != 0) && active && !ready && (count == LIMIT);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-style datapath: fetch, decode, execute,
// memory and writeback with a memory watchdog and sticky halt on error.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned OPC_W    = 6,
   parameter int unsigned ALUOP_W  = 6,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OPC_W-1:0]   opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_read,
   output logic               mem_write,
   output logic               iord,
   output logic               ir_write,
   output logic               mdr_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_source,
   output logic               reg_dst,
   output logic               reg_write,
   output logic               mem_to_reg,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               retire,
   output logic               halted,
   output logic [1:0]         err_code
);

   state_t     state;
   state_t     state_nxt;
   logic [1:0] err_q;
   logic [1:0] err_nxt;
   logic [5:0] op6;
   logic       wait_active;
   logic       wait_expired;

   assign op6 = 6'(opcode);

   always_comb begin
      wait_active = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   end

   mc_wait_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) u_wait_timer (
      .clk    (clk),
      .reset  (reset),
      .active (wait_active),
      .ready  (mem_ready),
      .expired(wait_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_FETCH;
         err_q <= ERR_NONE;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = err_q;
      case (state)
         S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            state_nxt = dispatch(op6);
            if (state_nxt == S_HALT) err_nxt = ERR_ILLEGAL;
         end
         S_EXEC_R:   state_nxt = S_WB_R;
         S_WB_R:     state_nxt = S_FETCH;
         S_EXEC_I:   state_nxt = S_WB_I;
         S_WB_I:     state_nxt = S_FETCH;
         S_BRANCH:   state_nxt = S_FETCH;
         S_JUMP:     state_nxt = S_FETCH;
         S_MEM_ADDR: state_nxt = (op6 == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
         S_MEM_WB:   state_nxt = S_FETCH;
         S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
         S_HALT:     state_nxt = S_HALT;
         default:    state_nxt = S_FETCH;
      endcase
      // expired already implies !mem_ready, so a same-cycle ready always wins.
      if (wait_expired) begin
         state_nxt = S_HALT;
         err_nxt   = ERR_TIMEOUT;
      end
   end

   // Reset masks every output so a pending access drops while reset is held.
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = '0;
      retire        = 1'b0;
      halted        = 1'b0;
      err_code      = ERR_NONE;
      if (!reset) begin
         alu_op   = ALUOP_W'(ALU_ADD);
         err_code = err_q;
         case (state)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               pc_source = PCSRC_ALU;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = SRCB_IMMSH;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_RT;
               alu_op    = ALUOP_W'(ALU_RTYPE);
            end
            S_WB_R: begin
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALUOP_W'(op6);
            end
            S_WB_I: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_src_b     = SRCB_RT;
               alu_op        = ALUOP_W'(ALU_SUB);
               pc_write_cond = 1'b1;
               pc_source     = PCSRC_ALUOUT;
               retire        = 1'b1;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = PCSRC_JUMP;
               retire    = 1'b1;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
               mem_read  = 1'b1;
               iord      = 1'b1;
               mdr_write = mem_ready;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               retire    = mem_ready;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
